// File: rtl/pid_sched.sv
// ============================================================================
// pid_sched : frame scheduler sharing one incremental PID core across NCH loops
// Rev 1.0
// ============================================================================
`default_nettype none

module pid_sched #(
  parameter int NCH      = 4,
  parameter int EW       = 9,
  parameter int UW       = 17,
  parameter int TICK_DIV = 1000,
  parameter int TMO      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*EW-1:0]   err_in,
  input  logic [NCH-1:0]      ch_en,
  input  logic                ovr_clr,
  output logic                core_start,
  output logic [EW-1:0]       core_ek,
  output logic [EW-1:0]       core_ek1,
  output logic [EW-1:0]       core_ek2,
  output logic [UW-1:0]       core_uk1,
  input  logic                core_done,
  input  logic [UW-1:0]       core_uk,
  output logic [NCH*UW-1:0]   uk_bus,
  output logic [NCH-1:0]      uk_valid,
  output logic                frame_done,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  localparam int c_chw = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_tcw = $clog2(TICK_DIV);
  localparam int c_wcw = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [c_chw-1:0]   ch_q;
  logic [c_tcw-1:0]   tcnt_q;
  logic [c_tcw-1:0]   tcnt_d;
  logic [c_wcw-1:0]   wcnt_q;
  logic               abort_q;
  logic [UW-1:0]      ukcap_q;

  logic [EW-1:0]      ek_q  [NCH];
  logic [EW-1:0]      ek1_q [NCH];
  logic [EW-1:0]      ek2_q [NCH];
  logic [UW-1:0]      uk1_q [NCH];
  logic [UW-1:0]      uk_q  [NCH];

  logic               core_start_q;
  logic               frame_done_q;
  logic [NCH-1:0]     uk_valid_q;
  logic               overrun_q;
  logic               timeout_q;

  logic               w_tick;
  logic               w_last_ch;
  logic               w_tmo_hit;

  assign w_tick    = (tcnt_q == c_tcw'(TICK_DIV - 1));
  assign w_last_ch = (ch_q == c_chw'(NCH - 1));
  assign w_tmo_hit = (state_q == S_WAIT) && !core_done && (wcnt_q == c_wcw'(TMO - 1));

  always_comb begin
    tcnt_d = w_tick ? '0 : tcnt_q + c_tcw'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      wcnt_q       <= '0;
      abort_q      <= 1'b0;
      ukcap_q      <= '0;
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      uk_valid_q   <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ek_q[i]  <= '0;
        ek1_q[i] <= '0;
        ek2_q[i] <= '0;
        uk1_q[i] <= '0;
        uk_q[i]  <= '0;
      end
    end else begin
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      uk_valid_q   <= '0;

      // Sticky flags: a set event in the same cycle beats the clear.
      if (w_tick && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
      if (w_tmo_hit) begin
        timeout_q <= 1'b1;
      end else if (ovr_clr) begin
        timeout_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (w_tick) begin
            for (int i = 0; i < NCH; i++) begin
              ek_q[i] <= err_in[i*EW +: EW];
            end
            ch_q    <= '0;
            state_q <= S_SEL;
          end
        end

        S_SEL: begin
          if (ch_en[ch_q]) begin
            core_start_q <= 1'b1;
            state_q      <= S_START;
          end else begin
            // A disabled loop restarts from a clean history when re-enabled.
            ek1_q[ch_q] <= '0;
            ek2_q[ch_q] <= '0;
            uk1_q[ch_q] <= '0;
            if (w_last_ch) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              ch_q <= ch_q + c_chw'(1);
            end
          end
        end

        S_START: begin
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (core_done) begin
            ukcap_q <= core_uk;
            abort_q <= 1'b0;
            state_q <= S_STORE;
          end else if (w_tmo_hit) begin
            abort_q <= 1'b1;
            state_q <= S_STORE;
          end else begin
            wcnt_q <= wcnt_q + c_wcw'(1);
          end
        end

        S_STORE: begin
          if (!abort_q) begin
            uk_q[ch_q]       <= ukcap_q;
            uk1_q[ch_q]      <= ukcap_q;
            ek2_q[ch_q]      <= ek1_q[ch_q];
            ek1_q[ch_q]      <= ek_q[ch_q];
            uk_valid_q[ch_q] <= 1'b1;
          end
          if (w_last_ch) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            ch_q    <= ch_q + c_chw'(1);
            state_q <= S_SEL;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_ek    = ek_q[ch_q];
  assign core_ek1   = ek1_q[ch_q];
  assign core_ek2   = ek2_q[ch_q];
  assign core_uk1   = uk1_q[ch_q];
  assign uk_valid   = uk_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_bus
    assign uk_bus[gi*UW +: UW] = uk_q[gi];
  end

endmodule

`default_nettype wire

// File: doc/pid_sched.md
# pid_sched

Multi-channel PID scheduler that time-shares one incremental PID compute core among NCH control loops. A sample-rate tick counter starts each control frame. On each frame the scheduler snapshots all channel errors, then walks the enabled channels in order. For each channel it hands the core that channel's error history (e_k, e_k-1, e_k-2, u_k-1), waits for the result and writes u_k back. It sits between the per-channel error sources and the shared `pid_top`-style arithmetic core, and owns all per-channel state.

## Interface
- NCH, 4: number of channels (2..16)
- EW, 9: error width, signed two's complement
- UW, 17: control output width, signed
- TICK_DIV, 1000: clk cycles per sample frame (≥ 8)
- TMO, 64: max cycles to wait for core_done before aborting a channel

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- err_in  in  NCH*EW  channel errors, ch i at [i*EW +: EW]
- ch_en  in  NCH  per-channel enable
- ovr_clr  in  1  clears sticky flags
- core_start  out  1  one-cycle pulse, operands valid
- core_ek, core_ek1, core_ek2  out  EW each  error history of current channel
- core_uk1  out  UW  previous output of current channel
- core_done  in  1  one-cycle pulse, core_uk valid
- core_uk  in  UW  core result
- uk_bus  out  NCH*UW  per-channel outputs, ch i at [i*UW +: UW]
- uk_valid  out  NCH  one-cycle pulse when ch i output updates
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high when the FSM is not in IDLE
- overrun  out  1  sticky: a tick arrived while busy
- timeout  out  1  sticky: a core call timed out

## Operation
- Tick counter counts 0..TICK_DIV-1 and wraps. The internal tick is high in the cycle the counter equals TICK_DIV-1.
- FSM states:
  - IDLE: on tick, snapshot err_in into ek latches, set ch=0, go to SEL.
  - SEL:
    - If ch_en[ch], go to START.
    - Otherwise clear that channel's ek1/ek2/uk1 history to 0; uk_bus for that channel holds its value. Then go to DONE if ch==NCH-1, else ch++ and stay in SEL.
  - START: core_start=1, go to WAIT. The wait counter is cleared.
  - WAIT:
    - On core_done, capture core_uk and go to STORE.
    - If the wait counter reaches TMO-1 without core_done, set timeout and go to STORE flagged as aborted.
  - STORE:
    - If not aborted: uk_bus[ch]←core_uk, uk1←core_uk, ek2←ek1, ek1←ek, uk_valid[ch]=1.
    - If aborted: no state change and no uk_valid.
    - Then go to DONE if ch==NCH-1, else ch++ and go to SEL.
  - DONE: frame_done=1, go to IDLE.
- core_ek/core_ek1/core_ek2/core_uk1 show the channel ch registers. They are stable from START through WAIT.
- core_done is ignored outside WAIT.
- A tick while FSM≠IDLE sets overrun and is dropped. The frame in progress completes normally.
- ovr_clr clears overrun and timeout. If a set event occurs in the same cycle, set wins.
- No arithmetic is done here. Widths pass through unchanged and signs are preserved.

## Timing
- Reset state: all outputs 0, FSM IDLE, ch=0, all history and uk registers 0, tick counter 0.
- rst asserted in any state returns to IDLE the next edge. Any core call in flight is abandoned, and a later core_done is ignored.
- Frame latency per enabled channel: SEL + START + WAIT(L) + STORE = L+3 cycles, where L is the number of cycles from core_start to core_done (L ≥ 1).
- Per disabled channel: 1 cycle. Plus 1 cycle for DONE.
- uk_valid[ch] and the uk_bus update occur in the same cycle (registered outputs visible the cycle after STORE).
- An all-disabled frame: NCH SEL cycles then frame_done.
- ch_en is sampled in SEL only. A change mid-frame affects only channels not yet visited.

## Test plan
1. Reset, NCH=4, all enabled, core model returns uk1+ek after L=5; err ch0..3 = 127, 63, 31, -64 (9'h1C0).
   - Frame 1: uk = 127, 63, 31, -64; uk_valid pulses in order 0..3.
   - frame_done at 4*8+1 = 33 cycles after tick.
2. Same setup, second frame with unchanged errors: uk = 254, 126, 62, -128; core_ek1 equals the previous ek during each call.
3. ch_en=4'b0101: only ch0 and ch2 call the core; ch1/ch3 history reads 0 on re-enable; frame length 2*8+2+1 = 19 cycles.
4. Core never asserts done on ch1, TMO=32:
   - timeout sets after 32 WAIT cycles; ch1 uk and history unchanged; ch2/ch3 still processed.
   - ovr_clr clears timeout.
5. TICK_DIV=16 with L=5, all enabled: tick arrives while busy, overrun=1, that frame is skipped; ovr_clr in the same cycle as a new overrun leaves overrun=1.
6. rst asserted in WAIT of ch2: next cycle busy=0, all uk_bus=0; a late core_done is ignored; the next tick starts from ch0.
